// File: rtl/mont_arb_pkg.sv
// Shared constants and types for the Montgomery multiplier arbiter.
// Optional performance counters in mont_mul_arbiter are enabled by MONT_ARB_PERF_EN.
package mont_arb_pkg;

  localparam int MOD      = 3329;
  localparam int WIDTH    = 12;
  localparam int LAT      = 4;
  localparam int TAGW     = 8;
  localparam int NREQ_MAX = 4;
  localparam int ID_W     = $clog2(NREQ_MAX);
  localparam int OUTST_W  = $clog2(LAT + 1);

  typedef logic [OUTST_W-1:0] outst_t;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic [TAGW-1:0] tag;
  } slot_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin arbiter: picks the first eligible index at or after ptr.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // k is the rotational distance from ptr; the smallest eligible distance wins.
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!any_grant && eligible[i] && ((i - int'(ptr) + N) % N) == k) begin
          grant[i]  = 1'b1;
          grant_idx = IW'(i);
          any_grant = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mont_mul_arbiter.sv
// Shares one fixed-latency Montgomery multiplier between NREQ requesters with tag/id tracking.
// Define MONT_ARB_PERF_EN to add per-requester grant counters and a stall counter.
module mont_mul_arbiter #(
  parameter int NREQ      = 2,
  parameter int WIDTH     = mont_arb_pkg::WIDTH,
  parameter int TAGW      = mont_arb_pkg::TAGW,
  parameter int LAT       = mont_arb_pkg::LAT,
  parameter int MAX_OUTST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [WIDTH-1:0]     rsp_r,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 mm_en,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  input  logic [WIDTH-1:0]     mm_r,
  output logic                 busy
`ifdef MONT_ARB_PERF_EN
  ,
  output logic [NREQ*32-1:0]   perf_grant_cnt,
  output logic [31:0]          perf_stall_cnt
`endif
);

  import mont_arb_pkg::*;

  slot_t            slot [LAT];
  outst_t           outst [NREQ];
  outst_t           eff_outst [NREQ];
  logic [ID_W-1:0]  ptr;
  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  rsp_hit;
  logic [ID_W-1:0]  grant_idx;
  logic             any_grant;
  slot_t            slot_in;

  always_comb begin
    rsp_hit = '0;
    for (int i = 0; i < NREQ; i++)
      rsp_hit[i] = slot[LAT-1].vld && (slot[LAT-1].id == ID_W'(i));
  end

  // A response leaving this cycle frees its credit immediately, so a requester at
  // its limit can be re-granted in the same cycle its oldest result returns.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eff_outst[i] = outst[i] - outst_t'(rsp_hit[i]);
      eligible[i]  = req_valid[i] && (int'(eff_outst[i]) < MAX_OUTST) && !rst && !flush;
    end
  end

  rr_arbiter #(.N(NREQ), .IW(ID_W)) u_rr (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_comb begin
    req_ready   = grant;
    mm_a        = any_grant ? req_a[int'(grant_idx)*WIDTH +: WIDTH] : '0;
    mm_b        = any_grant ? req_b[int'(grant_idx)*WIDTH +: WIDTH] : '0;
    slot_in.vld = any_grant;
    slot_in.id  = grant_idx;
    slot_in.tag = any_grant ? req_tag[int'(grant_idx)*TAGW +: TAGW] : '0;
    rsp_valid   = rsp_hit;
    rsp_r       = mm_r;
    rsp_tag     = slot[LAT-1].tag;
    busy        = 1'b0;
    for (int k = 0; k < LAT; k++)
      busy = busy | slot[k].vld;
  end

  // NOTE: the slot shift register is fully reset (not just vld) so rsp_tag reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_en <= 1'b0;
      ptr   <= '0;
      for (int k = 0; k < LAT; k++) slot[k] <= '0;
      for (int i = 0; i < NREQ; i++) outst[i] <= '0;
    end else begin
      mm_en   <= 1'b1;
      slot[0] <= slot_in;
      for (int k = 1; k < LAT; k++) slot[k] <= slot[k-1];
      if (any_grant)
        ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
      for (int i = 0; i < NREQ; i++)
        outst[i] <= outst[i] + outst_t'(grant[i]) - outst_t'(rsp_hit[i]);
      if (flush) begin
        for (int k = 0; k < LAT; k++) slot[k].vld <= 1'b0;
        for (int i = 0; i < NREQ; i++) outst[i] <= '0;
      end
    end
  end

`ifdef MONT_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'(grant[i]);
      if (|req_valid && !any_grant)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mont_mul_arbiter.sv
// Directed self-checking bench for mont_mul_arbiter with a behavioural modular multiplier.
module tb_mont_mul_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 12;
  localparam int TAGW  = 8;
  localparam int LAT   = 4;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*TAGW-1:0]  req_tag;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_r;
  logic [TAGW-1:0]       rsp_tag;
  logic                  mm_en;
  logic [WIDTH-1:0]      mm_a;
  logic [WIDTH-1:0]      mm_b;
  logic [WIDTH-1:0]      mm_r;
  logic                  busy;
`ifdef MONT_ARB_PERF_EN
  logic [NREQ*32-1:0]    perf_grant_cnt;
  logic [31:0]           perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  mont_mul_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .TAGW(TAGW), .LAT(LAT), .MAX_OUTST(2)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_tag(rsp_tag),
    .mm_en(mm_en), .mm_a(mm_a), .mm_b(mm_b), .mm_r(mm_r),
    .busy(busy)
`ifdef MONT_ARB_PERF_EN
    , .perf_grant_cnt(perf_grant_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  // Behavioural multiplier: canonical a*b mod 3329, LAT stages, advances on mm_en.
  logic [WIDTH-1:0] mm_pipe [LAT];
  always @(posedge clk) begin
    if (mm_en) begin
      mm_pipe[0] <= WIDTH'((32'(mm_a) * 32'(mm_b)) % 3329);
      for (int k = 1; k < LAT; k++) mm_pipe[k] <= mm_pipe[k-1];
    end
  end
  assign mm_r = mm_pipe[LAT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAGW-1:0] t);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_tag[i*TAGW +: TAGW] = t;
  endtask

  initial begin
    logic [9:0] rdy_pat;
    logic [9:0] rsp_pat;
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with requests pending to confirm ready stays low.
    req_valid = 2'b11;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_tag",   32'(rsp_tag),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mm_en",     32'(mm_en),     32'd0);
    check("rst_ready",     32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    tick();

    // Single request: 3*5 -> 15 after LAT cycles.
    set_req(0, 12'd3, 12'd5, 8'h11);
    req_valid = 2'b01;
    @(negedge clk);
    check("t1_mm_en",  32'(mm_en),     32'd1);
    check("t1_ready",  32'(req_ready), 32'b01);
    check("t1_mm_a",   32'(mm_a),      32'd3);
    check("t1_mm_b",   32'(mm_b),      32'd5);
    check("t1_busy0",  32'(busy),      32'd0);
    tick();
    req_valid = '0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("t1_rsp_valid", 32'(rsp_valid), (j == 4) ? 32'b01 : 32'b00);
      check("t1_busy",      32'(busy),      (j <= 4) ? 32'd1 : 32'd0);
      if (j == 4) begin
        check("t1_rsp_r",   32'(rsp_r),   32'd15);
        check("t1_rsp_tag", 32'(rsp_tag), 32'h11);
      end
      tick();
    end

    // Both requesters: ptr sits at 1 after the single grant to 0.
    set_req(0, 12'd100, 12'd100, 8'hA0);
    set_req(1, 12'd3328, 12'd3328, 8'hB1);
    for (int j = 0; j < 8; j++) begin
      req_valid = (j < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (j < 4) begin
        check("t2_ready", 32'(req_ready), (j % 2 == 0) ? 32'b10 : 32'b01);
        check("t2_rsp_idle", 32'(rsp_valid), 32'b00);
      end else begin
        check("t2_ready_off", 32'(req_ready), 32'b00);
        check("t2_rsp_valid", 32'(rsp_valid), (j % 2 == 0) ? 32'b10 : 32'b01);
        check("t2_rsp_r",     32'(rsp_r),     (j % 2 == 0) ? 32'd1 : 32'd13);
        check("t2_rsp_tag",   32'(rsp_tag),   (j % 2 == 0) ? 32'hB1 : 32'hA0);
      end
      tick();
    end

    // Outstanding limit of 2 on a lone requester: 2000*2000 -> 1871.
    set_req(0, 12'd2000, 12'd2000, 8'h30);
    rdy_pat = 10'b0000110011;
    rsp_pat = 10'b1100110000;
    for (int j = 0; j < 10; j++) begin
      req_valid = (j < 6) ? 2'b01 : 2'b00;
      @(negedge clk);
      check("t3_ready",     32'(req_ready), 32'(rdy_pat[j]));
      check("t3_rsp_valid", 32'(rsp_valid), 32'(rsp_pat[j]));
      if (rsp_pat[j]) check("t3_rsp_r", 32'(rsp_r), 32'd1871);
      tick();
    end

    // Flush with three ops in flight (grants 1,0,1 from ptr=1).
    set_req(0, 12'd4095, 12'd4095, 8'h40);
    set_req(1, 12'd4095, 12'd4095, 8'h41);
    for (int j = 0; j < 3; j++) begin
      req_valid = 2'b11;
      @(negedge clk);
      check("t4_ready", 32'(req_ready), (j == 1) ? 32'b01 : 32'b10);
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    check("t4_flush_ready", 32'(req_ready), 32'b00);
    check("t4_flush_mm_a",  32'(mm_a),      32'd0);
    check("t4_flush_rsp",   32'(rsp_valid), 32'b00);
    check("t4_flush_busy",  32'(busy),      32'd1);
    tick();
    flush = 1'b0; req_valid = '0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("t4_post_rsp",  32'(rsp_valid), 32'b00);
      check("t4_post_busy", 32'(busy),      32'd0);
      tick();
    end
    // Requester 1 had two in flight; both must be accepted again if its credit was cleared.
    for (int j = 0; j < 2; j++) begin
      req_valid = 2'b10;
      @(negedge clk);
      check("t4_outst_clr", 32'(req_ready), 32'b10);
      tick();
    end

    // Reset while those two are in flight.
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", 32'(req_ready), 32'b00);
    tick();
    @(negedge clk);
    check("t5_rst_mm_en", 32'(mm_en),     32'd0);
    check("t5_rst_busy",  32'(busy),      32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t5_no_rsp", 32'(rsp_valid), 32'b00);
      tick();
    end

    // After reset ptr=0: both valid for 10 cycles, grants 0,1,0,1...
    set_req(0, 12'd3, 12'd5, 8'h55);
    set_req(1, 12'd3328, 12'd3328, 8'h66);
    for (int j = 0; j < 14; j++) begin
      req_valid = (j < 10) ? 2'b11 : 2'b00;
      @(negedge clk);
      check("t6_ready", 32'(req_ready), (j >= 10) ? 32'b00 : ((j % 2 == 0) ? 32'b01 : 32'b10));
      if (j >= 4) begin
        check("t6_rsp_valid", 32'(rsp_valid), (j % 2 == 0) ? 32'b01 : 32'b10);
        check("t6_rsp_r",     32'(rsp_r),     (j % 2 == 0) ? 32'd15 : 32'd1);
        check("t6_rsp_tag",   32'(rsp_tag),   (j % 2 == 0) ? 32'h55 : 32'h66);
      end
      tick();
    end
`ifdef MONT_ARB_PERF_EN
    @(negedge clk);
    check("perf_grant0", perf_grant_cnt[31:0],  32'd5);
    check("perf_grant1", perf_grant_cnt[63:32], 32'd5);
    check("perf_stall",  perf_stall_cnt,        32'd0);
`endif
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("final_rst_rsp", 32'(rsp_valid), 32'b00);
`ifdef MONT_ARB_PERF_EN
    check("perf_rst_grant0", perf_grant_cnt[31:0],  32'd0);
    check("perf_rst_grant1", perf_grant_cnt[63:32], 32'd0);
    check("perf_rst_stall",  perf_stall_cnt,        32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
